vga_mode_ctrl: RTL and testbench
================================

Name: vga_mode_ctrl

Overview:
Register-programmed configuration and sequencing controller for the VGA timing generator. Holds a shadow set of timing parameters written over a simple register bus. Commits the shadow set to the live parameter outputs only at a frame boundary, then holds the generator in reset for a fixed settle period before running. Also owns generator enable/reset and raises a line-compare interrupt.

Parameters:
CNT_W, 10, width of timing counters and parameter fields
HOLD_CYCLES, 4, cycles tg_reset is held high after every (re)load; must be >=1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
reg_wr  in  1  write strobe, one cycle per write
reg_rd  in  1  read strobe
reg_addr  in  4  register address
reg_wdata  in  16  write data
reg_rdata  out  16  read data, registered
tg_h_counter  in  CNT_W  generator horizontal counter
tg_v_counter  in  CNT_W  generator vertical counter
tg_reset  out  1  reset to timing generator
tg_enabled  out  1  generator enable, high only in RUN
h_sync_start, h_sync_end, h_active_start, h_active_end  out  CNT_W each  live horizontal parameters
v_sync_start, v_sync_end, v_active_start, v_active_end  out  CNT_W each  live vertical parameters
h_pol, v_pol  out  1 each  live sync polarities
irq  out  1  level interrupt = irq_flag AND irq_en

Behaviour:
- Register map (unused bits read 0, writes to undefined addresses ignored):
  - 0 CTRL: b0 enable, b1 commit (write-one, self-clearing, reads 0), b2 h_pol, b3 v_pol, b4 irq_en.
  - 1-4: shadow H sync_start / sync_end / active_start / active_end, bits [CNT_W-1:0].
  - 5-8: shadow V same order.
  - 9 STATUS: b0 commit_pending (RO), b1 running (RO), b2 irq_flag (write 1 to clear).
  - 10 LINE_CMP.
- Read: reg_rdata updates the cycle after reg_rd. It holds its value otherwise.
- Reset values:
  - Shadow and live H = 0/96/160/799; V = 0/2/45/524; pols 0; enable 0; irq_en 0; LINE_CMP 0.
  - irq_flag 0; state DISABLED; tg_reset 1; tg_enabled 0; irq 0; reg_rdata 0.
- Frame boundary (FB): cycle where tg_h_counter==live h_active_end and tg_v_counter==live v_active_end.
- States:
  - DISABLED: tg_reset=1. Entered from any state one cycle after a write clearing enable. Clears pending. Entering DISABLED does not clear irq_flag.
  - DISABLED->HOLD: on write setting enable. The shadow set and pols are copied to live on that transition.
  - HOLD: tg_reset=1, hold counter counts HOLD_CYCLES cycles, then RUN.
  - RUN: tg_reset=0, tg_enabled=1. A commit write sets pending and moves to PENDING.
  - PENDING: generator keeps running on the old live set. On FB, copy shadow to live and enter HOLD next cycle.
  - Commit while PENDING: no effect, since the copy takes the latest shadow anyway.
  - Commit while DISABLED or HOLD: ignored, because HOLD/enable already loads the shadow.
- Shadow registers are writable in every state. Live outputs change only on the DISABLED->HOLD and PENDING FB copies.
- A CTRL write with enable=0 and commit=1: disable wins, no pending.
- Line compare:
  - In RUN or PENDING, tg_h_counter==0 and tg_v_counter==LINE_CMP sets irq_flag.
  - If the flag is set and W1C-cleared in the same cycle, set wins.
- Equality compares are full CNT_W width. No arithmetic on parameters; the controller does not validate ordering.

Decomposition:
- Shared package: register address constants, CTRL/STATUS bit indices, state enum, reset default constants (shared with the bench).
- One sub-module, vga_mode_regs: shadow register file plus read mux.
- FSM, live copy and irq logic stay in the top.

Test Plan:
- Reset, then write CTRL=1 -> tg_reset high exactly 4 cycles, then tg_enabled=1; live outputs = defaults 0/96/160/799, 0/2/45/524.
- In RUN, write H active_end=899 then CTRL=0x3 -> h_active_end stays 799 until the FB cycle (h=799, v=524). Next cycle: live=899 and tg_reset=1 for 4 cycles.
- In PENDING, write CTRL=0x2 (enable=0, commit=1) -> DISABLED next cycle, STATUS b0=0, live unchanged.
- LINE_CMP=10, irq_en=1, running -> irq rises one cycle after h=0,v=10. Write STATUS=0x4 on the same cycle as a new match -> flag stays 1.
- reg_rd at addr 9 during PENDING -> next-cycle rdata=0x3. Read of addr 12 -> 0.
- Assert reset mid-HOLD -> all outputs return to reset values next cycle; shadow back to defaults.

Source files
------------

// File: rtl/vga_mode_ctrl_pkg.sv
// vga_mode_ctrl_pkg: register map, bit indices, states and reset defaults for vga_mode_ctrl
package vga_mode_ctrl_pkg;
  localparam logic [3:0] A_CTRL   = 4'd0;
  localparam logic [3:0] A_H0     = 4'd1;
  localparam logic [3:0] A_V0     = 4'd5;
  localparam logic [3:0] A_STATUS = 4'd9;
  localparam logic [3:0] A_LCMP   = 4'd10;
  localparam int B_EN = 0, B_COMMIT = 1, B_HPOL = 2, B_VPOL = 3, B_IRQEN = 4;
  localparam int S_PEND = 0, S_RUN = 1, S_IRQ = 2;
  typedef enum logic [1:0] {DISABLED, HOLD, RUN, PENDING} state_t;
  localparam int H_DEF [4] = '{0, 96, 160, 799};
  localparam int V_DEF [4] = '{0, 2, 45, 524};
endpackage

// File: rtl/vga_mode_ctrl_regs.sv
// vga_mode_regs: shadow timing/control registers and registered read mux
module vga_mode_regs
  import vga_mode_ctrl_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_wr,
  input  logic                  reg_rd,
  input  logic [3:0]            reg_addr,
  input  logic [15:0]           reg_wdata,
  input  logic [2:0]            status,
  output logic                  h_pol,
  output logic                  v_pol,
  output logic                  irq_en,
  output logic [CNT_W-1:0]      line_cmp,
  output logic [3:0][CNT_W-1:0] sh_h,
  output logic [3:0][CNT_W-1:0] sh_v,
  output logic [15:0]           reg_rdata
);
  logic        enable;
  logic [15:0] rd_val;
  logic [3:0]  a_h, a_v;
  assign a_h = reg_addr - A_H0;
  assign a_v = reg_addr - A_V0;
  always_comb begin
    rd_val = '0;
    if (reg_addr == A_CTRL) rd_val = 16'({irq_en, v_pol, h_pol, 1'b0, enable});
    if (a_h < 4'd4) rd_val = 16'(sh_h[a_h[1:0]]);
    if (a_v < 4'd4) rd_val = 16'(sh_v[a_v[1:0]]);
    if (reg_addr == A_STATUS) rd_val = 16'(status);
    if (reg_addr == A_LCMP) rd_val = 16'(line_cmp);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      enable <= 1'b0;
      h_pol <= 1'b0;
      v_pol <= 1'b0;
      irq_en <= 1'b0;
      line_cmp <= '0;
      reg_rdata <= '0;
      for (int i = 0; i < 4; i++) begin
        sh_h[i] <= CNT_W'(H_DEF[i]);
        sh_v[i] <= CNT_W'(V_DEF[i]);
      end
    end else begin
      if (reg_wr && reg_addr == A_CTRL) begin
        enable <= reg_wdata[B_EN];
        h_pol <= reg_wdata[B_HPOL];
        v_pol <= reg_wdata[B_VPOL];
        irq_en <= reg_wdata[B_IRQEN];
      end
      if (reg_wr && a_h < 4'd4) sh_h[a_h[1:0]] <= reg_wdata[CNT_W-1:0];
      if (reg_wr && a_v < 4'd4) sh_v[a_v[1:0]] <= reg_wdata[CNT_W-1:0];
      if (reg_wr && reg_addr == A_LCMP) line_cmp <= reg_wdata[CNT_W-1:0];
      if (reg_rd) reg_rdata <= rd_val;
    end
  end
endmodule

// File: rtl/vga_mode_ctrl.sv
// vga_mode_ctrl: frame-synchronous timing parameter commit, generator sequencing and line-compare irq
module vga_mode_ctrl
  import vga_mode_ctrl_pkg::*;
#(
  parameter int CNT_W       = 10,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_wr,
  input  logic             reg_rd,
  input  logic [3:0]       reg_addr,
  input  logic [15:0]      reg_wdata,
  output logic [15:0]      reg_rdata,
  input  logic [CNT_W-1:0] tg_h_counter,
  input  logic [CNT_W-1:0] tg_v_counter,
  output logic             tg_reset,
  output logic             tg_enabled,
  output logic [CNT_W-1:0] h_sync_start,
  output logic [CNT_W-1:0] h_sync_end,
  output logic [CNT_W-1:0] h_active_start,
  output logic [CNT_W-1:0] h_active_end,
  output logic [CNT_W-1:0] v_sync_start,
  output logic [CNT_W-1:0] v_sync_end,
  output logic [CNT_W-1:0] v_active_start,
  output logic [CNT_W-1:0] v_active_end,
  output logic             h_pol,
  output logic             v_pol,
  output logic             irq
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  state_t                  state;
  logic [HW-1:0]           hold_cnt;
  logic [3:0][CNT_W-1:0]   sh_h, sh_v, live_h, live_v;
  logic [CNT_W-1:0]        line_cmp;
  logic                    sh_h_pol, sh_v_pol, irq_en, irq_flag;
  logic                    ctrl_wr, running, fb, lc_hit, irq_clr;
  assign ctrl_wr = reg_wr && reg_addr == A_CTRL;
  assign running = state == RUN || state == PENDING;
  assign fb = tg_h_counter == live_h[3] && tg_v_counter == live_v[3];
  assign lc_hit = running && tg_h_counter == '0 && tg_v_counter == line_cmp;
  assign irq_clr = reg_wr && reg_addr == A_STATUS && reg_wdata[S_IRQ];
  assign {h_sync_start, h_sync_end, h_active_start, h_active_end} = {live_h[0], live_h[1], live_h[2], live_h[3]};
  assign {v_sync_start, v_sync_end, v_active_start, v_active_end} = {live_v[0], live_v[1], live_v[2], live_v[3]};
  assign irq = irq_flag && irq_en;
  vga_mode_regs #(.CNT_W(CNT_W)) u_regs (
    .clk(clk), .reset(reset), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .status({irq_flag, running, state == PENDING}),
    .h_pol(sh_h_pol), .v_pol(sh_v_pol), .irq_en(irq_en), .line_cmp(line_cmp),
    .sh_h(sh_h), .sh_v(sh_v), .reg_rdata(reg_rdata)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DISABLED;
      hold_cnt <= '0;
      tg_reset <= 1'b1;
      tg_enabled <= 1'b0;
      irq_flag <= 1'b0;
      h_pol <= 1'b0;
      v_pol <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        live_h[i] <= CNT_W'(H_DEF[i]);
        live_v[i] <= CNT_W'(V_DEF[i]);
      end
    end else begin
      irq_flag <= lc_hit || (irq_flag && !irq_clr);
      if (ctrl_wr && !reg_wdata[B_EN]) begin
        state <= DISABLED;
        tg_reset <= 1'b1;
        tg_enabled <= 1'b0;
      end else begin
        case (state)
          DISABLED: if (ctrl_wr) begin
            state <= HOLD;
            hold_cnt <= '0;
            live_h <= sh_h;
            live_v <= sh_v;
            h_pol <= reg_wdata[B_HPOL];
            v_pol <= reg_wdata[B_VPOL];
          end
          HOLD: if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            state <= RUN;
            tg_reset <= 1'b0;
            tg_enabled <= 1'b1;
          end else hold_cnt <= hold_cnt + 1'b1;
          RUN: if (ctrl_wr && reg_wdata[B_COMMIT]) state <= PENDING;
          PENDING: if (fb) begin
            state <= HOLD;
            hold_cnt <= '0;
            tg_reset <= 1'b1;
            tg_enabled <= 1'b0;
            live_h <= sh_h;
            live_v <= sh_v;
            h_pol <= sh_h_pol;
            v_pol <= sh_v_pol;
          end
          default: state <= DISABLED;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vga_mode_ctrl.sv
// tb_vga_mode_ctrl: directed vector table, corner sequences and random run against a behavioural model
module tb_vga_mode_ctrl;
  import vga_mode_ctrl_pkg::*;
  localparam int HOLD = 4;
  logic clk = 0, reset = 1, reg_wr = 0, reg_rd = 0;
  logic [3:0] reg_addr = 0;
  logic [15:0] reg_wdata = 0, reg_rdata;
  logic [9:0] tg_h_counter = 5, tg_v_counter = 5;
  logic tg_reset, tg_enabled, h_pol, v_pol, irq;
  logic [9:0] h_sync_start, h_sync_end, h_active_start, h_active_end;
  logic [9:0] v_sync_start, v_sync_end, v_active_start, v_active_end;
  int total = 0, bad = 0;

  vga_mode_ctrl #(.CNT_W(10), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .tg_h_counter(tg_h_counter),
    .tg_v_counter(tg_v_counter), .tg_reset(tg_reset), .tg_enabled(tg_enabled),
    .h_sync_start(h_sync_start), .h_sync_end(h_sync_end), .h_active_start(h_active_start),
    .h_active_end(h_active_end), .v_sync_start(v_sync_start), .v_sync_end(v_sync_end),
    .v_active_start(v_active_start), .v_active_end(v_active_end), .h_pol(h_pol),
    .v_pol(v_pol), .irq(irq)
  );

  always #5 clk = ~clk;

  // behavioural model: enabled flag + remaining hold cycles + pending flag
  int m_sh_h[4], m_sh_v[4], m_live_h[4], m_live_v[4], m_hold, m_lcmp;
  bit m_en, m_hpol, m_vpol, m_irqen, m_lhpol, m_lvpol, m_flag, m_pend;
  logic [15:0] m_rdata;

  task automatic model_reset();
    m_sh_h = H_DEF; m_sh_v = V_DEF; m_live_h = H_DEF; m_live_v = V_DEF;
    m_en = 0; m_hpol = 0; m_vpol = 0; m_irqen = 0; m_lhpol = 0; m_lvpol = 0;
    m_flag = 0; m_pend = 0; m_hold = 0; m_lcmp = 0; m_rdata = 0;
  endtask

  function automatic logic [15:0] model_read(int a);
    bit run = m_en && m_hold == 0;
    if (a == 0) return {11'd0, m_irqen, m_vpol, m_hpol, 1'b0, m_en};
    if (a >= 1 && a <= 4) return 16'(m_sh_h[a-1]);
    if (a >= 5 && a <= 8) return 16'(m_sh_v[a-5]);
    if (a == 9) return {13'd0, m_flag, run, m_pend};
    if (a == 10) return 16'(m_lcmp);
    return 16'd0;
  endfunction

  task automatic model_step();
    int a = int'(reg_addr);
    int h = int'(tg_h_counter), v = int'(tg_v_counter);
    bit run = m_en && m_hold == 0;
    bit fb = h == m_live_h[3] && v == m_live_v[3];
    bit ctrl = reg_wr && a == 0;
    if (reset) begin model_reset(); return; end
    if (reg_rd) m_rdata = model_read(a);
    m_flag = (run && h == 0 && v == m_lcmp) || (m_flag && !(reg_wr && a == 9 && reg_wdata[2]));
    if (ctrl && !reg_wdata[0]) begin
      m_en = 0; m_pend = 0; m_hold = 0;
    end else if (ctrl && !m_en) begin
      m_en = 1; m_hold = HOLD; m_live_h = m_sh_h; m_live_v = m_sh_v;
      m_lhpol = reg_wdata[2]; m_lvpol = reg_wdata[3];
    end else if (m_hold > 0) m_hold--;
    else if (m_pend && fb) begin
      m_live_h = m_sh_h; m_live_v = m_sh_v; m_lhpol = m_hpol; m_lvpol = m_vpol;
      m_hold = HOLD; m_pend = 0;
    end else if (m_en && ctrl && reg_wdata[1]) m_pend = 1;
    if (ctrl) begin m_hpol = reg_wdata[2]; m_vpol = reg_wdata[3]; m_irqen = reg_wdata[4]; end
    if (reg_wr && a >= 1 && a <= 4) m_sh_h[a-1] = int'(reg_wdata[9:0]);
    if (reg_wr && a >= 5 && a <= 8) m_sh_v[a-5] = int'(reg_wdata[9:0]);
    if (reg_wr && a == 10) m_lcmp = int'(reg_wdata[9:0]);
  endtask

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(bit wr, bit rd, int addr, int wd, int h, int v);
    reg_wr = wr; reg_rd = rd; reg_addr = 4'(addr); reg_wdata = 16'(wd);
    tg_h_counter = 10'(h); tg_v_counter = 10'(v);
  endtask

  function automatic logic [127:0] dut_live();
    return {h_pol, v_pol, h_sync_start, h_sync_end, h_active_start, h_active_end,
            v_sync_start, v_sync_end, v_active_start, v_active_end};
  endfunction

  function automatic logic [127:0] live_of(bit hp, bit vp, int lh[4], int lv[4]);
    return {hp, vp, 10'(lh[0]), 10'(lh[1]), 10'(lh[2]), 10'(lh[3]),
            10'(lv[0]), 10'(lv[1]), 10'(lv[2]), 10'(lv[3])};
  endfunction

  typedef struct {
    bit wr, rd;
    int addr, wd, h, v;
    bit tr, te;
    int hae, rdx;
    bit irq;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(bit wr, bit rd, int addr, int wd, int h, int v,
                              bit tr, bit te, int hae, int rdx, bit irq);
    vec_t r;
    r.wr = wr; r.rd = rd; r.addr = addr; r.wd = wd; r.h = h; r.v = v;
    r.tr = tr; r.te = te; r.hae = hae; r.rdx = rdx; r.irq = irq;
    return r;
  endfunction

  task automatic check_reset_state(string tag);
    chk({tag, " tg_reset"}, tg_reset, 1);
    chk({tag, " tg_enabled"}, tg_enabled, 0);
    chk({tag, " irq"}, irq, 0);
    chk({tag, " rdata"}, reg_rdata, 0);
    chk({tag, " live"}, dut_live(), live_of(0, 0, H_DEF, V_DEF));
  endtask

  initial begin
    model_reset();
    vt.push_back(mk(1,0,0,1,5,5, 1,0,799,0,0));
    for (int i = 0; i < 3; i++) vt.push_back(mk(0,0,0,0,5,5, 1,0,799,0,0));
    vt.push_back(mk(0,0,0,0,5,5, 0,1,799,0,0));
    vt.push_back(mk(1,0,4,899,5,5, 0,1,799,0,0));
    vt.push_back(mk(1,0,0,3,5,5, 0,1,799,0,0));
    vt.push_back(mk(0,1,9,0,5,5, 0,1,799,3,0));
    vt.push_back(mk(0,1,12,0,5,5, 0,1,799,0,0));
    vt.push_back(mk(0,0,0,0,799,0, 0,1,799,0,0));
    vt.push_back(mk(0,0,0,0,799,524, 1,0,899,0,0));
    for (int i = 0; i < 3; i++) vt.push_back(mk(0,0,0,0,5,5, 1,0,899,0,0));
    vt.push_back(mk(0,0,0,0,5,5, 0,1,899,0,0));
    vt.push_back(mk(1,0,0,3,5,5, 0,1,899,0,0));
    vt.push_back(mk(1,0,4,700,5,5, 0,1,899,0,0));
    vt.push_back(mk(1,0,0,2,5,5, 1,0,899,0,0));
    vt.push_back(mk(0,1,9,0,5,5, 1,0,899,0,0));
    vt.push_back(mk(1,0,0,'h11,5,5, 1,0,700,0,0));
    for (int i = 0; i < 3; i++) vt.push_back(mk(0,0,0,0,5,5, 1,0,700,0,0));
    vt.push_back(mk(0,0,0,0,5,5, 0,1,700,0,0));
    vt.push_back(mk(1,0,10,10,5,5, 0,1,700,0,0));
    vt.push_back(mk(0,0,0,0,0,10, 0,1,700,0,1));
    vt.push_back(mk(0,0,0,0,5,5, 0,1,700,0,1));
    vt.push_back(mk(1,0,9,4,0,10, 0,1,700,0,1));
    vt.push_back(mk(1,0,9,4,5,5, 0,1,700,0,0));
    vt.push_back(mk(0,1,0,0,5,5, 0,1,700,'h11,0));
    vt.push_back(mk(0,1,4,0,5,5, 0,1,700,'h2BC,0));
    vt.push_back(mk(0,1,9,0,5,5, 0,1,700,'h2,0));

    reset = 1;
    step(); step();
    check_reset_state("reset");
    reset = 0;
    foreach (vt[i]) begin
      drv(vt[i].wr, vt[i].rd, vt[i].addr, vt[i].wd, vt[i].h, vt[i].v);
      step();
      chk($sformatf("row%0d tg_reset", i), tg_reset, vt[i].tr);
      chk($sformatf("row%0d tg_enabled", i), tg_enabled, vt[i].te);
      chk($sformatf("row%0d h_active_end", i), h_active_end, vt[i].hae);
      chk($sformatf("row%0d rdata", i), reg_rdata, vt[i].rdx);
      chk($sformatf("row%0d irq", i), irq, vt[i].irq);
    end

    // reset in the middle of a HOLD restores defaults, including the shadow set
    drv(1,0,0,0,5,5); step();
    drv(1,0,0,1,5,5); step();
    drv(0,0,0,0,5,5); step();
    chk("midhold tg_reset", tg_reset, 1);
    chk("midhold live", dut_live(), live_of(0, 0, '{0,96,160,700}, V_DEF));
    reset = 1; step(); reset = 0;
    check_reset_state("midhold reset");
    drv(0,1,4,0,5,5); step();
    chk("midhold shadow hae", reg_rdata, 799);
    drv(0,1,10,0,5,5); step();
    chk("midhold line_cmp", reg_rdata, 0);

    for (int n = 0; n < 4000; n++) begin
      int r = $urandom % 8;
      int a = (r < 3) ? 0 : int'($urandom % 16);
      int wd = int'($urandom % 65536);
      if (a == 0) wd = ($urandom % 8 == 0) ? (wd & 'hFFFE) : (wd | 1);
      drv($urandom % 3 == 0, $urandom % 2 == 0, a, wd,
          ($urandom % 3 == 0) ? 0 : ($urandom % 3 == 0) ? m_live_h[3] : int'($urandom % 1024),
          ($urandom % 3 == 0) ? m_lcmp : ($urandom % 2 == 0) ? m_live_v[3] : int'($urandom % 1024));
      reset = ($urandom % 500 == 0);
      step();
      chk($sformatf("rnd%0d tg_reset", n), tg_reset, !(m_en && m_hold == 0));
      chk($sformatf("rnd%0d tg_enabled", n), tg_enabled, m_en && m_hold == 0);
      chk($sformatf("rnd%0d irq", n), irq, m_flag && m_irqen);
      chk($sformatf("rnd%0d rdata", n), reg_rdata, m_rdata);
      chk($sformatf("rnd%0d live", n), dut_live(), live_of(m_lhpol, m_lvpol, m_live_h, m_live_v));
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
